rr_grant_encoder: RTL and testbench
===================================

Name: rr_grant_encoder

Overview:
- Sequential N:log2(N) encoder and the inverse of the register-file write-enable decoder.
- Takes N level-sensitive request lines, picks one round-robin and presents its encoded index on a valid/ready output channel.
- Returns a one-hot acknowledge to the winning requester on handshake.
- Sits between write-back sources and the single register-file write port in the pipelined CPU.

Parameters:
- N, 4, number of requesters; power of two, N >= 2.
- IDX_W, $clog2(N), width of the encoded index; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request lines; req[i]=1 means source i wants the port.
- out_valid  output  1  registered; out_idx holds a granted request.
- out_idx  output  IDX_W  registered; encoded index of the granted source.
- out_ready  input  1  consumer accepts out_idx this cycle.
- ack  output  N  one-hot; ack[out_idx]=1 only in the handshake cycle.

Behaviour:
- Reset (synchronous, active-high):
  - Next edge: out_valid=0, out_idx=0, round-robin pointer ptr=0, FSM=IDLE.
  - Reset has priority over every other event.
  - ack is forced to 0 while reset=1, including when out_valid=1 and out_ready=1.
- FSM has two states, IDLE (out_valid=0) and HOLD (out_valid=1).
- Selection function pick(mask, ptr): first set bit of mask searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrapping); also reports whether any bit is set.
- IDLE:
  - If |req, next edge enter HOLD, out_idx=pick(req, ptr), out_valid=1.
  - Latency is one cycle from request to out_valid.
  - If req=0, stay IDLE and hold out_idx.
- HOLD, out_ready=0:
  - out_valid, out_idx, ptr all hold, regardless of req changes.
  - A request dropped before ack is a protocol violation; it is not checked and the grant still stands.
- HOLD, out_ready=1 (handshake):
  - ack = one-hot(out_idx), combinational in the same cycle.
  - Next edge: ptr = (out_idx+1) mod N, wrapping via IDX_W-bit overflow.
  - Next winner = pick(req & ~one-hot(out_idx), new ptr). The just-granted bit is masked because its owner only drops req after seeing ack.
  - If a winner exists, stay HOLD with the new out_idx (back-to-back, one grant per cycle); otherwise go to IDLE with out_valid=0.
- ack is 0 in every cycle without a handshake.
- out_idx and out_valid never change while out_valid=1 and out_ready=0.
- Fairness: with all N bits continuously requesting, each index is granted exactly once in every N consecutive handshakes.

Decomposition:
- Shared package (cpu_pkg): default N, IDX_W derivation, and the state enum typedef {IDLE, HOLD}.
- One natural sub-module: rr_pick, combinational (mask[N], ptr[IDX_W]) -> (idx[IDX_W], any).
  - Rotate the mask right by ptr, apply a fixed priority encoder, then add ptr back mod N.
- Top level holds the FSM, the ptr/out_idx/out_valid registers and the ack decode.

Test Plan (N=4):
1. Reset: assert reset 2 cycles with req=1111, out_ready=1 -> out_valid=0, out_idx=00, ack=0000 throughout; first cycle after release still out_valid=0.
2. Sparse requests: ptr=0, req=0101, out_ready=1, requester drops a bit after its ack -> cycle+1 idx=0, ack=0001; cycle+2 idx=2, ack=0100; cycle+3 out_valid=0.
3. Backpressure: req=1000, out_ready=0 for 3 cycles -> out_valid=1, idx=3 stable, ack=0000. Raise out_ready -> ack=1000 that cycle, then ptr=0 and IDLE.
4. Fairness: req=1111 with requesters re-raising after ack, out_ready=1 for 8 cycles -> idx sequence 0,1,2,3,0,1,2,3, exactly one ack bit per cycle.
5. Wrap: after a grant of idx 2 (ptr=3), req=0011 -> next idx=0, then idx=1.
6. Reset mid-operation: HOLD with idx=1, out_ready=1, reset=1 in the same cycle -> ack=0000; next cycle out_valid=0, ptr=0. After release, req=0011 -> idx=0.

Source files
------------

// File: rtl/rr_grant_encoder_pkg.sv
// Shared constants for the round-robin grant encoder: default width,
// index-width helper and the two-state FSM encoding.
package rr_grant_encoder_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_HOLD = HOLD;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of mask searching upward
// from ptr with wrap-around, plus an any-set flag.
module rr_pick
  import rr_grant_encoder_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] first;

  // Rotating right by ptr puts the highest-priority candidate at bit 0.
  always_comb begin
    rot = N'({mask, mask} >> ptr);
  end

  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) first = IDX_W'(i);
    end
  end

  // N is a power of two, so IDX_W-bit overflow gives the mod-N wrap.
  assign idx = first + ptr;
  assign any = |mask;

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin N:log2(N) grant encoder feeding the register-file write port;
// presents the winner on a valid/ready channel and acks it on handshake.
//
// state | meaning
// IDLE  | no grant outstanding, out_valid=0
// HOLD  | grant in out_idx waiting for out_ready, out_valid=1
module rr_grant_encoder
  import rr_grant_encoder_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic [N-1:0]     ack
);

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [N-1:0]     granted;
  logic [N-1:0]     pick_mask;
  logic             pick_any;
  logic             handshake;

  assign out_valid = (state == ST_HOLD);
  assign granted   = N'(1) << out_idx;
  assign next_ptr  = out_idx + IDX_W'(1);
  assign handshake = out_valid & out_ready & ~reset;
  assign ack       = handshake ? granted : '0;

  // In HOLD the picker already looks at the post-handshake view: the current
  // owner is masked since it only drops req after seeing ack.
  assign pick_mask = (state == ST_HOLD) ? (req & ~granted) : req;
  assign pick_ptr  = (state == ST_HOLD) ? next_ptr : ptr;

  rr_pick #(.N(N)) u_pick (
    .mask (pick_mask),
    .ptr  (pick_ptr),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      out_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state   <= ST_HOLD;
            out_idx <= pick_idx;
          end
        end
        default: begin
          if (out_ready) begin
            ptr <= next_ptr;
            if (pick_any) out_idx <= pick_idx;
            else          state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Self-checking bench for rr_grant_encoder: directed vector table for the
// scenario sequences, then random traffic against a behavioural model.
module tb_rr_grant_encoder;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic          out_ready;
  logic [N-1:0]  ack;

  int checks = 0;
  int errors = 0;

  bit m_valid;
  int m_idx;
  int m_ptr;

  typedef struct {
    bit            rst;
    logic [N-1:0]  req;
    bit            rdy;
    bit            v;
    logic [IW-1:0] idx;
    logic [N-1:0]  ack;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  rr_grant_encoder #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .ack       (ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Round-robin search from p upward, wrapping at N.
  function automatic int mpick(input logic [N-1:0] m, input int p, output bit found);
    found = 0;
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) begin
        found = 1;
        return (p + k) % N;
      end
    end
    return 0;
  endfunction

  task automatic model_update(input bit r, input logic [N-1:0] q, input bit rd);
    bit            f;
    int            w;
    logic [N-1:0]  m;
    if (r) begin
      m_valid = 0; m_idx = 0; m_ptr = 0;
    end else if (!m_valid) begin
      w = mpick(q, m_ptr, f);
      if (f) begin
        m_valid = 1; m_idx = w;
      end
    end else if (rd) begin
      m_ptr = (m_idx + 1) % N;
      m = q;
      m[m_idx] = 1'b0;
      w = mpick(m, m_ptr, f);
      if (f) m_idx = w;
      else   m_valid = 0;
    end
  endtask

  task automatic step(input bit r, input logic [N-1:0] q, input bit rd,
                      input bit ev, input logic [IW-1:0] ei, input logic [N-1:0] ea,
                      input string tag);
    @(negedge clk);
    reset = r; req = q; out_ready = rd;
    #1;
    check({tag, ".valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".idx"},   32'(out_idx),   32'(ei));
    check({tag, ".ack"},   32'(ack),       32'(ea));
    @(posedge clk);
    model_update(r, q, rd);
  endtask

  initial begin
    reset = 1'b1; req = '0; out_ready = 1'b0;
    m_valid = 0; m_idx = 0; m_ptr = 0;
    @(posedge clk);

    // reset held with everything requesting and ready
    tbl.push_back('{1, 4'b1111, 1, 0, 2'd0, 4'b0000});
    tbl.push_back('{1, 4'b1111, 1, 0, 2'd0, 4'b0000});
    tbl.push_back('{0, 4'b0000, 1, 0, 2'd0, 4'b0000});
    // sparse requests, bit 0 dropped after its ack
    tbl.push_back('{0, 4'b0101, 1, 0, 2'd0, 4'b0000});
    tbl.push_back('{0, 4'b0101, 1, 1, 2'd0, 4'b0001});
    tbl.push_back('{0, 4'b0100, 1, 1, 2'd2, 4'b0100});
    tbl.push_back('{0, 4'b0000, 1, 0, 2'd2, 4'b0000});
    // backpressure on idx 3
    tbl.push_back('{0, 4'b1000, 0, 0, 2'd2, 4'b0000});
    tbl.push_back('{0, 4'b1000, 0, 1, 2'd3, 4'b0000});
    tbl.push_back('{0, 4'b1000, 0, 1, 2'd3, 4'b0000});
    tbl.push_back('{0, 4'b1000, 0, 1, 2'd3, 4'b0000});
    tbl.push_back('{0, 4'b1000, 1, 1, 2'd3, 4'b1000});
    tbl.push_back('{0, 4'b0000, 1, 0, 2'd3, 4'b0000});
    // fairness: all requesting, ptr back at 0
    tbl.push_back('{0, 4'b1111, 1, 0, 2'd3, 4'b0000});
    for (int k = 0; k < 8; k++)
      tbl.push_back('{0, 4'b1111, 1, 1, IW'(k % N), 4'b0001 << (k % N)});
    // wrap: grant idx 2 leaves ptr=3, then req=0011 gives 0 then 1
    tbl.push_back('{0, 4'b1111, 1, 1, 2'd0, 4'b0001});
    tbl.push_back('{0, 4'b1111, 1, 1, 2'd1, 4'b0010});
    tbl.push_back('{0, 4'b0011, 1, 1, 2'd2, 4'b0100});
    tbl.push_back('{0, 4'b0011, 1, 1, 2'd0, 4'b0001});
    // reset during a would-be handshake on idx 1
    tbl.push_back('{1, 4'b0010, 1, 1, 2'd1, 4'b0000});
    tbl.push_back('{0, 4'b0011, 1, 0, 2'd0, 4'b0000});
    tbl.push_back('{0, 4'b0011, 1, 1, 2'd0, 4'b0001});
    tbl.push_back('{0, 4'b0010, 1, 1, 2'd1, 4'b0010});
    tbl.push_back('{0, 4'b0000, 1, 0, 2'd1, 4'b0000});

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].req, tbl[i].rdy, tbl[i].v, tbl[i].idx, tbl[i].ack,
           $sformatf("vec%0d", i));

    for (int c = 0; c < 400; c++) begin
      bit            r;
      bit            rd;
      logic [N-1:0]  q;
      logic [N-1:0]  ea;
      r  = ($urandom_range(0, 49) == 0);
      rd = ($urandom_range(0, 9) < 7);
      q  = N'($urandom);
      ea = '0;
      if (m_valid && rd && !r) ea[m_idx] = 1'b1;
      step(r, q, rd, m_valid, IW'(m_idx), ea, $sformatf("rnd%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
